// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write-back arbiter.
package rf_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    // Requester identity, stored as the last-granted requester.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. Bit 0 = ALU, bit 1 = LSU; owns the last_grant flop.
module rr_arb2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       xfer,
    output logic [1:0] gnt
);

    req_e last_grant_q, last_grant_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= REQ_LSU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (xfer) begin
            last_grant_d = gnt[1] ? REQ_LSU : REQ_ALU;
        end
    end

    // On a tie, the requester that did not win last time goes first.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant_q == REQ_LSU) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates ALU/LSU write-backs onto the register-file write port and tracks pending writes.
// Define RF_WB_BYPASS_EN to add two same-cycle bypass lookup channels.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_addr,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic                  issue_en,
    input  logic [REG_ADDR_W-1:0] issue_rd,
`ifdef RF_WB_BYPASS_EN
    input  logic [REG_ADDR_W-1:0] byp_addr1,
    input  logic [REG_ADDR_W-1:0] byp_addr2,
    output logic                  byp_hit1,
    output logic                  byp_hit2,
    output logic [DATA_WIDTH-1:0] byp_data1,
    output logic [DATA_WIDTH-1:0] byp_data2,
`endif
    output logic [NUM_REGS-1:0]   busy,
    output logic                  rf_wr_en,
    output logic [REG_ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_WIDTH-1:0] rf_wr_data
);

    logic [1:0]            req, gnt;
    logic                  xfer_any;
    logic                  wr_d;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  rf_wr_en_q;
    logic [REG_ADDR_W-1:0] rf_wr_addr_q;
    logic [DATA_WIDTH-1:0] rf_wr_data_q;
    logic [NUM_REGS-1:0]   busy_q, busy_d;

    assign req = {lsu_valid, alu_valid};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .xfer  (wr_d),
        .gnt   (gnt)
    );

    assign alu_ready = gnt[0];
    assign lsu_ready = gnt[1];

    assign xfer_any = |(req & gnt);
    assign sel_addr = gnt[1] ? lsu_addr : alu_addr;
    assign sel_data = gnt[1] ? lsu_data : alu_data;
    // x0 transfers complete the handshake but neither write nor move the priority.
    assign wr_d     = xfer_any && (sel_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wr_en_q   <= 1'b0;
            rf_wr_addr_q <= '0;
            rf_wr_data_q <= '0;
        end else begin
            rf_wr_en_q <= wr_d;
            if (wr_d) begin
                rf_wr_addr_q <= sel_addr;
                rf_wr_data_q <= sel_data;
            end
        end
    end

    // Set is applied after clear so a newer pending write wins.
    always_comb begin
        busy_d = busy_q;
        if (rf_wr_en_q && (rf_wr_addr_q != '0)) begin
            busy_d[rf_wr_addr_q] = 1'b0;
        end
        if (issue_en && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy       = busy_q;
    assign rf_wr_en   = rf_wr_en_q;
    assign rf_wr_addr = rf_wr_addr_q;
    assign rf_wr_data = rf_wr_data_q;

`ifdef RF_WB_BYPASS_EN
    assign byp_hit1  = rf_wr_en_q && (rf_wr_addr_q == byp_addr1) && (byp_addr1 != '0);
    assign byp_hit2  = rf_wr_en_q && (rf_wr_addr_q == byp_addr2) && (byp_addr2 != '0);
    assign byp_data1 = rf_wr_data_q;
    assign byp_data2 = rf_wr_data_q;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vectors, a transaction-level model and literal checks.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid, lsu_valid, issue_en;
    logic        alu_ready, lsu_ready;
    logic [4:0]  alu_addr, lsu_addr, issue_rd;
    logic [31:0] alu_data, lsu_data;
    logic [31:0] busy;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
`ifdef RF_WB_BYPASS_EN
    logic [4:0]  byp_addr1, byp_addr2;
    logic        byp_hit1, byp_hit2;
    logic [31:0] byp_data1, byp_data2;
`endif

    int total = 0;
    int bad   = 0;

    rf_wb_arbiter #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_addr   (lsu_addr),
        .lsu_data   (lsu_data),
        .issue_en   (issue_en),
        .issue_rd   (issue_rd),
`ifdef RF_WB_BYPASS_EN
        .byp_addr1  (byp_addr1),
        .byp_addr2  (byp_addr2),
        .byp_hit1   (byp_hit1),
        .byp_hit2   (byp_hit2),
        .byp_data1  (byp_data1),
        .byp_data2  (byp_data2),
`endif
        .busy       (busy),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who wins this cycle, given the valids and who won the last real write.
    // Returns -1 for nobody, 0 for ALU, 1 for LSU.
    function automatic int pick(input logic a, input logic l, input int last);
        if (a && l) return (last == 1) ? 0 : 1;
        if (a) return 0;
        if (l) return 1;
        return -1;
    endfunction

    typedef struct {
        bit          en;
        logic [4:0]  addr;
        logic [31:0] data;
        int          last;
        logic [31:0] busy;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t step(input mstate_t s, input logic av, input logic [4:0] aa,
                                     input logic [31:0] ad, input logic lv,
                                     input logic [4:0] la, input logic [31:0] ld,
                                     input logic ie, input logic [4:0] ir);
        mstate_t n = s;
        int w = pick(av, lv, s.last);
        logic [4:0] a;
        if (s.en && s.addr != 5'd0) n.busy[s.addr] = 1'b0;
        if (ie && ir != 5'd0) n.busy[ir] = 1'b1;
        n.en = 1'b0;
        if (w >= 0) begin
            a = (w == 1) ? la : aa;
            if (a != 5'd0) begin
                n.en   = 1'b1;
                n.addr = a;
                n.data = (w == 1) ? ld : ad;
                n.last = w;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= '{en: 1'b0, addr: 5'd0, data: 32'd0, last: 1, busy: 32'd0};
        end else begin
            m <= step(m, alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data,
                      issue_en, issue_rd);
        end
    end

    always @(negedge clk) begin
        chk("m_alu_ready", 32'(alu_ready), 32'(pick(alu_valid, lsu_valid, m.last) == 0));
        chk("m_lsu_ready", 32'(lsu_ready), 32'(pick(alu_valid, lsu_valid, m.last) == 1));
        chk("m_rf_wr_en", 32'(rf_wr_en), 32'(m.en));
        chk("m_rf_wr_addr", 32'(rf_wr_addr), 32'(m.addr));
        chk("m_rf_wr_data", rf_wr_data, m.data);
        chk("m_busy", busy, m.busy);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        issue_en  = 1'b0;
        alu_addr  = 5'd0;
        lsu_addr  = 5'd0;
        issue_rd  = 5'd0;
        alu_data  = 32'd0;
        lsu_data  = 32'd0;
`ifdef RF_WB_BYPASS_EN
        byp_addr1 = 5'd0;
        byp_addr2 = 5'd0;
`endif
        #1;
        chk("rst_wr_en", 32'(rf_wr_en), 32'd0);
        chk("rst_wr_addr", 32'(rf_wr_addr), 32'd0);
        chk("rst_wr_data", rf_wr_data, 32'd0);
        chk("rst_busy", busy, 32'd0);
        tick();
        rst_n = 1'b1;

        // Single ALU write-back
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hA5A5_0001;
        settle();
        chk("single_alu_ready", 32'(alu_ready), 32'd1);
        chk("single_lsu_ready", 32'(lsu_ready), 32'd0);
        tick();
        alu_valid = 1'b0;
        chk("single_wr_en", 32'(rf_wr_en), 32'd1);
        chk("single_wr_addr", 32'(rf_wr_addr), 32'd5);
        chk("single_wr_data", rf_wr_data, 32'hA5A5_0001);
        tick();
        chk("single_wr_en_drop", 32'(rf_wr_en), 32'd0);
        chk("single_addr_hold", 32'(rf_wr_addr), 32'd5);

        // Tie straight after reset: ALU first, then LSU
        reset_pulse();
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h0000_0033;
        lsu_valid = 1'b1; lsu_addr = 5'd7; lsu_data = 32'h0000_0077;
        settle();
        chk("tie_alu_first", 32'(alu_ready), 32'd1);
        chk("tie_lsu_wait", 32'(lsu_ready), 32'd0);
        tick();
        alu_valid = 1'b0;
        settle();
        chk("tie_lsu_second", 32'(lsu_ready), 32'd1);
        chk("tie_addr_3", 32'(rf_wr_addr), 32'd3);
        tick();
        lsu_valid = 1'b0;
        chk("tie_addr_7", 32'(rf_wr_addr), 32'd7);
        chk("tie_data_7", rf_wr_data, 32'h0000_0077);

        // Continuous requests alternate
        alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'h0000_1010;
        lsu_valid = 1'b1; lsu_addr = 5'd11; lsu_data = 32'h0000_1111;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk("alt_alu", 32'(alu_ready), 32'((i % 2) == 0));
            chk("alt_lsu", 32'(lsu_ready), 32'((i % 2) == 1));
            tick();
        end
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        tick();

        // Scoreboard set then clear by an LSU write two cycles later
        issue_en = 1'b1; issue_rd = 5'd9;
        tick();
        issue_en = 1'b0;
        chk("sb_set", busy, 32'h0000_0200);
        tick();
        chk("sb_hold", busy, 32'h0000_0200);
        lsu_valid = 1'b1; lsu_addr = 5'd9; lsu_data = 32'h0000_0099;
        tick();
        lsu_valid = 1'b0;
        chk("sb_wr_en", 32'(rf_wr_en), 32'd1);
        chk("sb_busy_during_wr", busy, 32'h0000_0200);
        tick();
        chk("sb_cleared", busy, 32'd0);

        // Same-cycle issue and write to x9: set wins
        lsu_valid = 1'b1; lsu_addr = 5'd9; lsu_data = 32'h0000_009A;
        tick();
        lsu_valid = 1'b0;
        issue_en = 1'b1; issue_rd = 5'd9;
        chk("sb_same_wr_addr", 32'(rf_wr_addr), 32'd9);
        tick();
        issue_en = 1'b0;
        chk("sb_set_wins", busy, 32'h0000_0200);

        // x0 write and x0 issue; priority must not move
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFF_FFFF;
        issue_en = 1'b1; issue_rd = 5'd0;
        settle();
        chk("x0_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        issue_en = 1'b0;
        chk("x0_no_wr", 32'(rf_wr_en), 32'd0);
        chk("x0_data_hold", rf_wr_data, 32'h0000_009A);
        chk("x0_busy", busy, 32'h0000_0200);
        alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h0000_0044;
        lsu_valid = 1'b1; lsu_addr = 5'd12; lsu_data = 32'h0000_00CC;
        settle();
        chk("x0_keeps_prio", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        chk("pre_rst_wr_en", 32'(rf_wr_en), 32'd1);
        chk("pre_rst_wr_addr", 32'(rf_wr_addr), 32'd4);
`ifdef RF_WB_BYPASS_EN
        byp_addr1 = 5'd4;
        byp_addr2 = 5'd0;
        settle();
        chk("byp_hit1", 32'(byp_hit1), 32'd1);
        chk("byp_data1", byp_data1, 32'h0000_0044);
        chk("byp_hit2_x0", 32'(byp_hit2), 32'd0);
`endif

        // Asynchronous reset while a write is in flight
        rst_n = 1'b0;
        lsu_valid = 1'b0;
        #1;
        chk("async_wr_en", 32'(rf_wr_en), 32'd0);
        chk("async_busy", busy, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", 32'(rf_wr_en), 32'd0);
        alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h0000_0001;
        settle();
        chk("post_rst_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        chk("post_rst_wr", 32'(rf_wr_en), 32'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
